// File: rtl/uart_apb_rx_drain.sv
// uart_apb_rx_drain
//   APB3 master placed directly downstream of a CoreUARTapb slave (same PCLK).
//   Optionally programs the UART baud/config registers once after reset, then
//   drains received bytes by reading offset 0x04 whenever RXRDY is high, and
//   buffers each byte with its {framing, parity} error tag in a local FWFT FIFO
//   presented as a valid/ready stream.
//
//   Build option: define UART_RXDRAIN_INIT_EN to enable the two init writes
//   (0x08 <= BAUD_VALUE[7:0], 0x0C <= {BAUD_VALUE[12:8], CFG_BITS}).
//   Without it, reset enters IDLE and BAUD_VALUE/CFG_BITS are unused.
//
// Ports
//   PCLK, PRESET                   clock, synchronous active-high reset
//   M_PADDR/PSEL/PENABLE/PWRITE/
//   M_PWDATA (out), M_PRDATA/
//   M_PREADY (in)                  APB3 master port to the UART
//   RXRDY, PARITY_ERR,
//   FRAMING_ERR, OVERFLOW (in)     UART status flags
//   RX_DATA, RX_ERR, RX_VALID(out)
//   RX_READY (in)                  output byte stream, pop on RX_VALID & RX_READY
//   FIFO_LEVEL (out)               FIFO occupancy
//   OVF_STICKY (out)               UART overflow seen since reset
//   INIT_DONE (out)                init writes (if any) complete

module uart_apb_rx_drain #(
  parameter int unsigned FIFO_AW    = 4,
  parameter logic [12:0] BAUD_VALUE = 13'd0,
  parameter logic [2:0]  CFG_BITS   = 3'b001,
  parameter int unsigned HOLDOFF    = 2
) (
  input  logic               PCLK,
  input  logic               PRESET,
  output logic [4:0]         M_PADDR,
  output logic               M_PSEL,
  output logic               M_PENABLE,
  output logic               M_PWRITE,
  output logic [7:0]         M_PWDATA,
  input  logic [7:0]         M_PRDATA,
  input  logic               M_PREADY,
  input  logic               RXRDY,
  input  logic               PARITY_ERR,
  input  logic               FRAMING_ERR,
  input  logic               OVERFLOW,
  output logic [7:0]         RX_DATA,
  output logic [1:0]         RX_ERR,
  output logic               RX_VALID,
  input  logic               RX_READY,
  output logic [FIFO_AW:0]   FIFO_LEVEL,
  output logic               OVF_STICKY,
  output logic               INIT_DONE
);

  localparam int unsigned DEPTH  = 2 ** FIFO_AW;
  localparam int unsigned LW     = FIFO_AW + 1;
  localparam int unsigned EW     = 10;
  localparam int unsigned HW     = 8;
  // A zero holdoff would let IDLE resample RXRDY before the UART drops it.
  localparam int unsigned HOLD_N = (HOLDOFF < 1) ? 1 : HOLDOFF;

  localparam logic [4:0] ADDR_RXDATA = 5'h04;

  typedef enum logic [2:0] {
    S_INIT_C1,
    S_INIT_C2,
    S_IDLE,
    S_RD_SETUP,
    S_RD_ACCESS,
    S_HOLD
  } state_t;

`ifdef UART_RXDRAIN_INIT_EN
  localparam state_t     RESET_STATE = S_INIT_C1;
  localparam logic [4:0] ADDR_BAUD_LO = 5'h08;
  localparam logic [4:0] ADDR_CTRL    = 5'h0C;
`else
  localparam state_t     RESET_STATE = S_IDLE;
`endif

  state_t          r_state;
  logic [4:0]      r_paddr;
  logic            r_psel;
  logic            r_penable;
  logic            r_pwrite;
  logic [7:0]      r_pwdata;
  logic            r_init_done;
  logic            r_ovf;
  logic [HW-1:0]   r_hold;
  // Capture stage between the APB completion edge and the FIFO write.
  logic            r_cap_vld;
  logic [EW-1:0]   r_cap;

`ifdef UART_RXDRAIN_INIT_EN
  // Write sub-phase: 0 = not issued, 1 = setup, 2 = access.
  logic [1:0]      r_ph;
`else
  logic            w_unused_cfg;
  assign w_unused_cfg = ^{BAUD_VALUE, CFG_BITS};
`endif

  logic [EW-1:0]      r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [LW-1:0]      r_level;
  logic               r_valid;

  logic               w_pop;
  logic               w_push;
  logic [LW-1:0]      w_level_nxt;
  logic               w_fifo_room;

  assign w_fifo_room = (r_level < LW'(DEPTH));
  assign w_pop       = r_valid & RX_READY;
  // A push into a full FIFO is only accepted alongside a pop.
  assign w_push      = r_cap_vld & (w_fifo_room | w_pop);

  // Next occupancy.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // APB master sequencer, init writes and read drain.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state     <= RESET_STATE;
      r_paddr     <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_init_done <= 1'b0;
      r_ovf       <= 1'b0;
      r_hold      <= '0;
      r_cap_vld   <= 1'b0;
      r_cap       <= '0;
`ifdef UART_RXDRAIN_INIT_EN
      r_ph        <= 2'd0;
`endif
    end else begin
      r_ovf     <= r_ovf | OVERFLOW;
      r_cap_vld <= 1'b0;
      case (r_state)
`ifdef UART_RXDRAIN_INIT_EN
        S_INIT_C1, S_INIT_C2: begin
          case (r_ph)
            2'd0: begin
              r_psel    <= 1'b1;
              r_penable <= 1'b0;
              r_pwrite  <= 1'b1;
              if (r_state == S_INIT_C1) begin
                r_paddr  <= ADDR_BAUD_LO;
                r_pwdata <= BAUD_VALUE[7:0];
              end else begin
                r_paddr  <= ADDR_CTRL;
                r_pwdata <= {BAUD_VALUE[12:8], CFG_BITS};
              end
              r_ph <= 2'd1;
            end
            2'd1: begin
              r_penable <= 1'b1;
              r_ph      <= 2'd2;
            end
            default: begin
              if (M_PREADY) begin
                r_psel    <= 1'b0;
                r_penable <= 1'b0;
                r_pwrite  <= 1'b0;
                r_ph      <= 2'd0;
                if (r_state == S_INIT_C1) begin
                  r_state <= S_INIT_C2;
                end else begin
                  r_state     <= S_IDLE;
                  r_init_done <= 1'b1;
                end
              end
            end
          endcase
        end
`endif
        S_IDLE: begin
          r_init_done <= 1'b1;
          if (RXRDY && w_fifo_room) begin
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= ADDR_RXDATA;
            r_pwdata  <= '0;
            r_state   <= S_RD_SETUP;
          end
        end
        S_RD_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_RD_ACCESS;
        end
        S_RD_ACCESS: begin
          if (M_PREADY) begin
            r_cap     <= {FRAMING_ERR, PARITY_ERR, M_PRDATA};
            r_cap_vld <= 1'b1;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_hold    <= '0;
            r_state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Give the UART time to drop RXRDY before it is looked at again.
          if (r_hold == HW'(HOLD_N - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  // First-word-fall-through FIFO.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_valid  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_cap;
        r_wr_ptr        <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end
      r_level <= w_level_nxt;
      r_valid <= (w_level_nxt != '0);
    end
  end

  assign M_PADDR    = r_paddr;
  assign M_PSEL     = r_psel;
  assign M_PENABLE  = r_penable;
  assign M_PWRITE   = r_pwrite;
  assign M_PWDATA   = r_pwdata;
  assign RX_DATA    = r_mem[r_rd_ptr][7:0];
  assign RX_ERR     = r_mem[r_rd_ptr][9:8];
  assign RX_VALID   = r_valid;
  assign FIFO_LEVEL = r_level;
  assign OVF_STICKY = r_ovf;
  assign INIT_DONE  = r_init_done;

endmodule

// File: tb/tb_uart_apb_rx_drain.sv
// Bench for uart_apb_rx_drain: emulates the UART APB slave (configurable wait
// states) and checks the DUT against a transaction-level queue model each cycle,
// plus directed literal expectations.
module tb_uart_apb_rx_drain;

  localparam int unsigned FIFO_AW = 2;
  localparam int unsigned DEPTH   = 4;

  logic        pclk = 1'b0;
  logic        rst;
  logic [4:0]  m_paddr;
  logic        m_psel, m_penable, m_pwrite;
  logic [7:0]  m_pwdata;
  logic [7:0]  prdata;
  logic        m_pready;
  logic        rxrdy, pe, fe, ovf_in, rx_ready;
  logic [7:0]  rx_data;
  logic [1:0]  rx_err;
  logic        rx_valid;
  logic [FIFO_AW:0] fifo_level;
  logic        ovf_sticky, init_done;

  int          ws_n;
  int          acc_cnt;

  int          n_pass  = 0;
  int          n_total = 0;

  // Model state
  logic [9:0]  q[$];
  logic [9:0]  pend;
  logic        pend_vld;
  logic        ovf_m, done_m;
  int          rd_count = 0;
  int          wr_n;
  logic [4:0]  wr_addr [4];
  logic [7:0]  wr_data [4];
  logic [4:0]  setup_addr;

  always #5 pclk = ~pclk;

  uart_apb_rx_drain #(
    .FIFO_AW(FIFO_AW), .BAUD_VALUE(13'h0A5B), .CFG_BITS(3'b011), .HOLDOFF(2)
  ) dut (
    .PCLK(pclk), .PRESET(rst),
    .M_PADDR(m_paddr), .M_PSEL(m_psel), .M_PENABLE(m_penable), .M_PWRITE(m_pwrite),
    .M_PWDATA(m_pwdata), .M_PRDATA(prdata), .M_PREADY(m_pready),
    .RXRDY(rxrdy), .PARITY_ERR(pe), .FRAMING_ERR(fe), .OVERFLOW(ovf_in),
    .RX_DATA(rx_data), .RX_ERR(rx_err), .RX_VALID(rx_valid), .RX_READY(rx_ready),
    .FIFO_LEVEL(fifo_level), .OVF_STICKY(ovf_sticky), .INIT_DONE(init_done)
  );

  // UART slave: ws_n wait cycles in every access phase.
  assign m_pready = (acc_cnt >= ws_n);
  always @(posedge pclk) begin
    if (m_psel && m_penable && !m_pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Transaction model: a completed read lands in the stream one edge later.
  always @(posedge pclk) begin
    if (rst) begin
      q.delete();
      pend_vld = 1'b0;
      ovf_m    = 1'b0;
      done_m   = 1'b0;
      wr_n     = 0;
    end else begin
      if (q.size() > 0 && rx_ready) void'(q.pop_front());
      if (pend_vld && q.size() < DEPTH) q.push_back(pend);
      pend_vld = 1'b0;
      if (m_psel && m_penable && m_pready) begin
        if (m_pwrite) begin
          if (wr_n < 4) begin
            wr_addr[wr_n] = m_paddr;
            wr_data[wr_n] = m_pwdata;
          end
          wr_n++;
        end else begin
          pend     = {fe, pe, prdata};
          pend_vld = 1'b1;
          rd_count++;
        end
      end
      if (ovf_in) ovf_m = 1'b1;
`ifdef UART_RXDRAIN_INIT_EN
      done_m = (wr_n >= 2);
`else
      done_m = 1'b1;
`endif
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge pclk) begin
    chk("level", 32'(fifo_level), 32'(q.size()));
    chk("valid", 32'(rx_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("head_data", 32'(rx_data), 32'(q[0][7:0]));
      chk("head_err", 32'(rx_err), 32'(q[0][9:8]));
    end
    chk("ovf_sticky", 32'(ovf_sticky), 32'(ovf_m));
    chk("init_done", 32'(init_done), 32'(done_m));
    chk("penable_wo_psel", 32'(m_penable & ~m_psel), 32'(0));
    if (m_psel && !m_penable) setup_addr = m_paddr;
    else if (m_penable) chk("addr_hold", 32'(m_paddr), 32'(setup_addr));
  end

  task automatic wait_rd(input int target, input int budget);
    int k = 0;
    while (rd_count < target && k < budget) begin
      @(negedge pclk);
      k++;
    end
    if (rd_count < target) chk("read_timeout", 32'(rd_count), 32'(target));
  endtask

  task automatic drain();
    int k = 0;
    rx_ready = 1'b1;
    while (fifo_level != 0 && k < 20) begin
      @(negedge pclk);
      k++;
    end
    rx_ready = 1'b0;
    chk("drain_empty", 32'(fifo_level), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int base, cnt;
    rst = 1'b1; rxrdy = 1'b0; pe = 1'b0; fe = 1'b0; ovf_in = 1'b0;
    rx_ready = 1'b0; prdata = 8'h00; ws_n = 0;
    repeat (3) @(negedge pclk);
    chk("rst_psel", 32'(m_psel), 32'(0));
    chk("rst_penable", 32'(m_penable), 32'(0));
    chk("rst_paddr", 32'(m_paddr), 32'(0));
    chk("rst_level", 32'(fifo_level), 32'(0));
    chk("rst_rx_data", 32'(rx_data), 32'(0));
    chk("rst_init_done", 32'(init_done), 32'(0));
    rst = 1'b0;
    @(negedge pclk);
`ifdef UART_RXDRAIN_INIT_EN
    chk("init_c1_psel", 32'(m_psel), 32'(1));
    chk("init_done_c1", 32'(init_done), 32'(0));
    repeat (4) @(negedge pclk);
    chk("init_done_c5", 32'(init_done), 32'(0));
    @(negedge pclk);
    chk("init_done_c6", 32'(init_done), 32'(1));
    chk("init_wr_count", 32'(wr_n), 32'(2));
    chk("init_wr0_addr", 32'(wr_addr[0]), 32'h08);
    chk("init_wr0_data", 32'(wr_data[0]), 32'h5B);
    chk("init_wr1_addr", 32'(wr_addr[1]), 32'h0C);
    chk("init_wr1_data", 32'(wr_data[1]), 32'h53);
`else
    chk("init_done_c1", 32'(init_done), 32'(1));
`endif

    // Single byte with latency checks
    prdata = 8'h3C; rxrdy = 1'b1;
    @(negedge pclk);
    chk("rd_setup_psel", 32'(m_psel), 32'(1));
    chk("rd_setup_penable", 32'(m_penable), 32'(0));
    chk("rd_addr", 32'(m_paddr), 32'h04);
    chk("rd_pwrite", 32'(m_pwrite), 32'(0));
    @(negedge pclk);
    chk("rd_access_penable", 32'(m_penable), 32'(1));
    @(negedge pclk);
    rxrdy = 1'b0;
    chk("rd_done_psel", 32'(m_psel), 32'(0));
    chk("valid_not_yet", 32'(rx_valid), 32'(0));
    @(negedge pclk);
    chk("single_valid", 32'(rx_valid), 32'(1));
    chk("single_data", 32'(rx_data), 32'h3C);
    chk("single_err", 32'(rx_err), 32'(0));
    chk("single_level", 32'(fifo_level), 32'(1));
    repeat (6) @(negedge pclk);
    chk("single_read_count", 32'(rd_count), 32'(1));
    drain();

    // Parity error tag
    prdata = 8'hA1; pe = 1'b1; rxrdy = 1'b1;
    wait_rd(2, 20);
    rxrdy = 1'b0; pe = 1'b0;
    @(negedge pclk);
    chk("parity_err_tag", 32'(rx_err), 32'(2'b01));
    chk("parity_data", 32'(rx_data), 32'hA1);
    drain();

    // Framing error tag
    prdata = 8'h7E; fe = 1'b1; rxrdy = 1'b1;
    wait_rd(3, 20);
    rxrdy = 1'b0; fe = 1'b0;
    @(negedge pclk);
    chk("framing_err_tag", 32'(rx_err), 32'(2'b10));
    chk("framing_data", 32'(rx_data), 32'h7E);
    repeat (3) @(negedge pclk);
    drain();

    // Full FIFO: exactly DEPTH reads, then one more per pop
    base = rd_count;
    rxrdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      prdata = 8'(8'h50 + rd_count);
      @(negedge pclk);
    end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (m_psel) cnt++;
    end
    chk("full_reads", 32'(rd_count - base), 32'(4));
    chk("full_level", 32'(fifo_level), 32'(4));
    chk("full_psel_quiet", 32'(cnt), 32'(0));
    rx_ready = 1'b1;
    @(negedge pclk);
    rx_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      prdata = 8'(8'h50 + rd_count);
      @(negedge pclk);
    end
    chk("full_reads_after_pop", 32'(rd_count - base), 32'(5));
    chk("full_level_after_pop", 32'(fifo_level), 32'(4));
    rxrdy = 1'b0;
    repeat (3) @(negedge pclk);
    drain();

    // Wait states: PREADY low for 3 access cycles
    ws_n = 3; prdata = 8'hC3; rxrdy = 1'b1;
    base = rd_count; cnt = 0;
    for (int k = 0; k < 30 && rd_count < base + 1; k++) begin
      @(negedge pclk);
      if (m_penable) cnt++;
    end
    rxrdy = 1'b0;
    chk("ws_penable_cycles", 32'(cnt), 32'(4));
    @(negedge pclk);
    chk("ws_data", 32'(rx_data), 32'hC3);
    repeat (5) @(negedge pclk);
    chk("ws_single_push", 32'(fifo_level), 32'(1));
    chk("ws_read_count", 32'(rd_count - base), 32'(1));
    ws_n = 0;

    // Overflow sticky
    ovf_in = 1'b1;
    @(negedge pclk);
    ovf_in = 1'b0;
    chk("ovf_set", 32'(ovf_sticky), 32'(1));
    repeat (3) @(negedge pclk);
    chk("ovf_held", 32'(ovf_sticky), 32'(1));

    // Reset in the middle of an access phase (FIFO holds one byte)
    ws_n = 10; rxrdy = 1'b1;
    cnt = 0;
    while (!m_penable && cnt < 20) begin
      @(negedge pclk);
      cnt++;
    end
    chk("mid_access_reached", 32'(m_penable), 32'(1));
    rst = 1'b1;
    @(negedge pclk);
    chk("midrst_psel", 32'(m_psel), 32'(0));
    chk("midrst_penable", 32'(m_penable), 32'(0));
    chk("midrst_level", 32'(fifo_level), 32'(0));
    chk("midrst_ovf", 32'(ovf_sticky), 32'(0));
    rst = 1'b0; rxrdy = 1'b0; ws_n = 0;
    @(negedge pclk);
`ifdef UART_RXDRAIN_INIT_EN
    chk("restart_init_psel", 32'(m_psel), 32'(1));
    chk("restart_init_addr", 32'(m_paddr), 32'h08);
    repeat (5) @(negedge pclk);
`else
    chk("restart_psel", 32'(m_psel), 32'(0));
`endif
    chk("restart_init_done", 32'(init_done), 32'(1));

    // Read after restart
    base = rd_count; prdata = 8'h99; rxrdy = 1'b1;
    wait_rd(base + 1, 20);
    rxrdy = 1'b0;
    @(negedge pclk);
    chk("post_rst_data", 32'(rx_data), 32'h99);
    chk("post_rst_level", 32'(fifo_level), 32'(1));
    repeat (4) @(negedge pclk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
